// File: rtl/owi_cmd_sequencer.sv
// One-wire slave command sequencer.
// Detects a master reset pulse on the bus, answers with a presence pulse,
// enables the command receiver and then decodes the received byte.
//
// Ports:
//   clk             single clock, all state on posedge
//   rst             asynchronous active-high reset
//   bus_in          synchronised one-wire bus level
//   bus_pull_low    1 = open-drain driver pulls the bus low (presence pulse)
//   en_cmd_recieve  enable to the command receiver, high throughout RECV
//   done_recieving  receiver reports a captured byte
//   frame           received command byte
//   cmd_valid       one-cycle strobe, cmd_code holds an accepted command
//   cmd_code        last accepted command byte
//   cmd_err         one-cycle strobe, unsupported byte or receive timeout
//   busy            high whenever the sequencer is not idle
module owi_cmd_sequencer #(
    parameter int unsigned RST_MIN  = 480,
    parameter int unsigned PRES_DLY = 15,
    parameter int unsigned PRES_LEN = 60,
    parameter int unsigned RECV_TO  = 600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bus_in,
    output logic       bus_pull_low,
    output logic       en_cmd_recieve,
    input  logic       done_recieving,
    input  logic [7:0] frame,
    output logic       cmd_valid,
    output logic [7:0] cmd_code,
    output logic       cmd_err,
    output logic       busy
);

    localparam int unsigned MAX_A   = (RST_MIN > RECV_TO) ? RST_MIN : RECV_TO;
    localparam int unsigned MAX_B   = (PRES_DLY > PRES_LEN) ? PRES_DLY : PRES_LEN;
    localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned LW      = $clog2(RST_MIN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_LOW,
        S_WAIT_REL,
        S_PRES_WAIT,
        S_PRESENCE,
        S_RECV,
        S_DISPATCH
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic [LW-1:0] lrun, lrun_n, lrun_inc;
    logic [7:0]    frame_q, frame_n;
    logic [7:0]    code_n;
    logic          valid_n, err_n;
    logic          pull_n, en_n, busy_n;
    logic          supported;

    // Saturating increments so no counter can ever wrap.
    assign cnt_inc  = (&cnt)  ? cnt  : cnt  + CW'(1);
    assign lrun_inc = (&lrun) ? lrun : lrun + LW'(1);

    assign supported = (frame_q == 8'h33) || (frame_q == 8'h55) ||
                       (frame_q == 8'hCC) || (frame_q == 8'hF0);

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            lrun           <= '0;
            frame_q        <= '0;
            bus_pull_low   <= 1'b0;
            en_cmd_recieve <= 1'b0;
            cmd_valid      <= 1'b0;
            cmd_err        <= 1'b0;
            cmd_code       <= 8'h00;
            busy           <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            lrun           <= lrun_n;
            frame_q        <= frame_n;
            bus_pull_low   <= pull_n;
            en_cmd_recieve <= en_n;
            cmd_valid      <= valid_n;
            cmd_err        <= err_n;
            cmd_code       <= code_n;
            busy           <= busy_n;
        end
    end

    // Next state, counters and next output values.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        lrun_n  = '0;        // low-run detector only counts inside RECV
        frame_n = frame_q;
        code_n  = cmd_code;
        valid_n = 1'b0;
        err_n   = 1'b0;

        case (state)
            S_IDLE: begin
                if (!bus_in) begin
                    state_n = S_RST_LOW;
                    cnt_n   = CW'(1);
                end
            end
            S_RST_LOW: begin
                if (bus_in) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_inc;
                    if (cnt_inc >= CW'(RST_MIN)) state_n = S_WAIT_REL;
                end
            end
            S_WAIT_REL: begin
                if (bus_in) begin
                    state_n = S_PRES_WAIT;
                    cnt_n   = '0;
                end
            end
            S_PRES_WAIT: begin
                if (cnt_inc >= CW'(PRES_DLY)) begin
                    state_n = S_PRESENCE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            S_PRESENCE: begin
                if (cnt_inc >= CW'(PRES_LEN)) begin
                    state_n = S_RECV;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            S_RECV: begin
                lrun_n = bus_in ? '0 : lrun_inc;
                // done wins over both a master reset and the timeout
                if (done_recieving) begin
                    state_n = S_DISPATCH;
                    frame_n = frame;
                    cnt_n   = '0;
                end else if (!bus_in && (lrun_inc >= LW'(RST_MIN))) begin
                    state_n = S_WAIT_REL;
                    cnt_n   = '0;
                    lrun_n  = '0;
                end else if (cnt_inc >= CW'(RECV_TO)) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                    err_n   = 1'b1;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            S_DISPATCH: begin
                state_n = S_IDLE;
                if (supported) begin
                    valid_n = 1'b1;
                    code_n  = frame_q;
                end else begin
                    err_n = 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase

        // Level outputs follow the state they will be registered alongside.
        pull_n = (state_n == S_PRESENCE);
        en_n   = (state_n == S_RECV);
        busy_n = (state_n != S_IDLE);
    end

endmodule

// File: tb/tb_owi_cmd_sequencer.sv
`timescale 1ns/1ps
module tb_owi_cmd_sequencer;

    typedef struct packed {
        logic       err;
        logic [7:0] code;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bus_in = 1'b1;
    logic       done_recieving = 1'b0;
    logic [7:0] frame = 8'h00;
    logic       bus_pull_low, en_cmd_recieve, cmd_valid, cmd_err, busy;
    logic [7:0] cmd_code;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb_q[$];
    logic [7:0] exp_code = 8'h00;

    owi_cmd_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .bus_in         (bus_in),
        .bus_pull_low   (bus_pull_low),
        .en_cmd_recieve (en_cmd_recieve),
        .done_recieving (done_recieving),
        .frame          (frame),
        .cmd_valid      (cmd_valid),
        .cmd_code       (cmd_code),
        .cmd_err        (cmd_err),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Scoreboard: every strobe must match the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (cmd_valid || cmd_err)) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL strobe_unexpected: got valid=%0b err=%0b code=%h, required no strobe",
                         cmd_valid, cmd_err, cmd_code);
            end else begin
                e = sb_q.pop_front();
                if ({cmd_valid, cmd_err, cmd_code} !== {~e.err, e.err, e.code})
                    $display("FAIL strobe_match: got valid=%0b err=%0b code=%h, required valid=%0b err=%0b code=%h",
                             cmd_valid, cmd_err, cmd_code, ~e.err, e.err, e.code);
                else
                    n_pass++;
            end
        end
    end

    initial begin
        #(10 * 80000);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Master reset of low_len cycles, then wait for the receive window.
    task automatic reach_recv(input int low_len);
        int w;
        bus_in = 1'b0;
        step(low_len);
        bus_in = 1'b1;
        w = 0;
        while (en_cmd_recieve !== 1'b1 && w < 200) begin step(1); w++; end
        n_checks++;
        if (en_cmd_recieve !== 1'b1) $display("FAIL recv_reached: en=%0b after %0d cycles, required 1", en_cmd_recieve, w);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus_in = 1'b1; done_recieving = 1'b0; frame = 8'h00;
        step(3);
        n_checks++;
        if ({bus_pull_low, en_cmd_recieve, cmd_valid, cmd_err, busy, cmd_code} !== 13'h0)
            $display("FAIL reset_outputs: got %b, required 0", {bus_pull_low, en_cmd_recieve, cmd_valid, cmd_err, busy, cmd_code});
        else n_pass++;
        rst = 1'b0;
        step(2);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_idle: busy=%0b, required 0", busy); else n_pass++;
    endtask

    task automatic test_presence_bad_cmd();
        int w, len;
        bus_in = 1'b0;
        step(500);
        bus_in = 1'b1;
        step(1);
        n_checks++;
        if ({bus_pull_low, busy} !== 2'b01) $display("FAIL pres_wait: pull=%0b busy=%0b, required 0 1", bus_pull_low, busy);
        else n_pass++;
        w = 0;
        while (bus_pull_low !== 1'b1 && w < 100) begin step(1); w++; end
        n_checks++;
        if (w != 15) $display("FAIL pres_delay: got %0d, required 15", w); else n_pass++;
        len = 0;
        while (bus_pull_low === 1'b1 && len < 100) begin step(1); len++; end
        n_checks++;
        if (len != 60) $display("FAIL pres_len: got %0d, required 60", len); else n_pass++;
        n_checks++;
        if (en_cmd_recieve !== 1'b1) $display("FAIL en_after_pres: got %0b, required 1", en_cmd_recieve); else n_pass++;
        step(100);
        frame = 8'hA5; done_recieving = 1'b1;
        sb_q.push_back('{1'b1, exp_code});
        step(1);
        done_recieving = 1'b0;
        n_checks++;
        if ({en_cmd_recieve, busy} !== 2'b01) $display("FAIL dispatch_a5: en=%0b busy=%0b, required 0 1", en_cmd_recieve, busy);
        else n_pass++;
        step(1);
        n_checks++;
        if ({cmd_err, cmd_valid, cmd_code, busy} !== {1'b1, 1'b0, 8'h00, 1'b0})
            $display("FAIL bad_cmd: err=%0b valid=%0b code=%h busy=%0b, required 1 0 00 0", cmd_err, cmd_valid, cmd_code, busy);
        else n_pass++;
        step(1);
        n_checks++;
        if (cmd_err !== 1'b0) $display("FAIL bad_cmd_pulse: err=%0b, required 0", cmd_err); else n_pass++;
    endtask

    task automatic test_good_cmd();
        reach_recv(500);
        step(569);
        frame = 8'hCC; done_recieving = 1'b1;
        sb_q.push_back('{1'b0, 8'hCC});
        exp_code = 8'hCC;
        step(1);
        done_recieving = 1'b0;
        n_checks++;
        if ({en_cmd_recieve, busy} !== 2'b01) $display("FAIL dispatch_cc: en=%0b busy=%0b, required 0 1", en_cmd_recieve, busy);
        else n_pass++;
        step(1);
        n_checks++;
        if ({cmd_valid, cmd_err, cmd_code, busy} !== {1'b1, 1'b0, 8'hCC, 1'b0})
            $display("FAIL good_cmd: valid=%0b err=%0b code=%h busy=%0b, required 1 0 cc 0", cmd_valid, cmd_err, cmd_code, busy);
        else n_pass++;
        step(1);
        n_checks++;
        if ({cmd_valid, cmd_code} !== {1'b0, 8'hCC}) $display("FAIL good_cmd_pulse: valid=%0b code=%h, required 0 cc", cmd_valid, cmd_code);
        else n_pass++;
    endtask

    task automatic test_short_low();
        logic seen;
        bus_in = 1'b0;
        step(479);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL short_low_busy: busy=%0b, required 1", busy); else n_pass++;
        bus_in = 1'b1;
        step(1);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL short_low_idle: busy=%0b, required 0", busy); else n_pass++;
        seen = 1'b0;
        repeat (100) begin step(1); if (bus_pull_low !== 1'b0 || busy !== 1'b0) seen = 1'b1; end
        n_checks++;
        if (seen !== 1'b0) $display("FAIL short_low_nopres: activity=%0b, required 0", seen); else n_pass++;
    endtask

    task automatic test_timeout();
        reach_recv(480);
        step(599);
        n_checks++;
        if ({en_cmd_recieve, cmd_err} !== 2'b10) $display("FAIL timeout_early: en=%0b err=%0b, required 1 0", en_cmd_recieve, cmd_err);
        else n_pass++;
        sb_q.push_back('{1'b1, exp_code});
        step(1);
        n_checks++;
        if ({cmd_err, en_cmd_recieve, busy} !== 3'b100)
            $display("FAIL timeout: err=%0b en=%0b busy=%0b, required 1 0 0", cmd_err, en_cmd_recieve, busy);
        else n_pass++;
        step(1);
        n_checks++;
        if ({cmd_err, busy} !== 2'b00) $display("FAIL timeout_pulse: err=%0b busy=%0b, required 0 0", cmd_err, busy);
        else n_pass++;
    endtask

    task automatic test_recv_abort_rst_presence();
        int w;
        reach_recv(500);
        step(10);
        bus_in = 1'b0;
        step(479);
        n_checks++;
        if (en_cmd_recieve !== 1'b1) $display("FAIL abort_early: en=%0b, required 1", en_cmd_recieve); else n_pass++;
        step(1);
        n_checks++;
        if ({en_cmd_recieve, busy, cmd_err} !== 3'b010)
            $display("FAIL abort: en=%0b busy=%0b err=%0b, required 0 1 0", en_cmd_recieve, busy, cmd_err);
        else n_pass++;
        step(50);
        n_checks++;
        if ({busy, bus_pull_low} !== 2'b10) $display("FAIL abort_wait: busy=%0b pull=%0b, required 1 0", busy, bus_pull_low);
        else n_pass++;
        bus_in = 1'b1;
        step(1);
        w = 0;
        while (bus_pull_low !== 1'b1 && w < 100) begin step(1); w++; end
        n_checks++;
        if (w != 15) $display("FAIL abort_pres_delay: got %0d, required 15", w); else n_pass++;
        step(5);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus_pull_low, en_cmd_recieve, busy} !== 3'b000)
            $display("FAIL rst_presence: pull=%0b en=%0b busy=%0b, required 0 0 0", bus_pull_low, en_cmd_recieve, busy);
        else n_pass++;
        exp_code = 8'h00;
        step(2);
        n_checks++;
        if (cmd_code !== 8'h00) $display("FAIL rst_code: got %h, required 00", cmd_code); else n_pass++;
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_rst_recv();
        reach_recv(500);
        step(100);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({en_cmd_recieve, busy} !== 2'b00) $display("FAIL rst_recv: en=%0b busy=%0b, required 0 0", en_cmd_recieve, busy);
        else n_pass++;
        step(1);
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_back_to_back();
        logic [7:0] codes [5] = '{8'h33, 8'h55, 8'hF0, 8'h5A, 8'hCC};
        int         dlys  [5] = '{3, 0, 599, 50, 10};
        logic       good;
        for (int i = 0; i < 5; i++) begin
            reach_recv(490);
            if (dlys[i] > 0) step(dlys[i]);
            n_checks++;
            if (en_cmd_recieve !== 1'b1) $display("FAIL b2b_in_recv[%0d]: en=%0b, required 1", i, en_cmd_recieve);
            else n_pass++;
            good = (codes[i] == 8'h33) || (codes[i] == 8'h55) || (codes[i] == 8'hCC) || (codes[i] == 8'hF0);
            frame = codes[i]; done_recieving = 1'b1;
            if (good) exp_code = codes[i];
            sb_q.push_back('{~good, exp_code});
            step(1);
            done_recieving = 1'b0; frame = 8'hFF;
            step(1);
            n_checks++;
            if ({cmd_valid, cmd_err, cmd_code} !== {good, ~good, exp_code})
                $display("FAIL b2b_strobe[%0d]: valid=%0b err=%0b code=%h, required %0b %0b %h",
                         i, cmd_valid, cmd_err, cmd_code, good, ~good, exp_code);
            else n_pass++;
        end
        step(5);
        frame = 8'h55; done_recieving = 1'b1;
        step(3);
        done_recieving = 1'b0;
        n_checks++;
        if ({busy, cmd_code} !== {1'b0, exp_code}) $display("FAIL done_idle: busy=%0b code=%h, required 0 %h", busy, cmd_code, exp_code);
        else n_pass++;
        step(3);
    endtask

    initial begin
        test_reset();
        test_presence_bad_cmd();
        test_good_cmd();
        test_short_low();
        test_timeout();
        test_recv_abort_rst_presence();
        test_rst_recv();
        test_back_to_back();
        n_checks++;
        if (sb_q.size() != 0) $display("FAIL scoreboard_drain: %0d pending, required 0", sb_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
